// File: rtl/display_scanner.sv
// Time-multiplexed driver for a four-digit active-low seven-segment display.
// Latches all four digit codes once per frame and scans them with a blanking gap per slot.
module display_scanner #(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] display0,
  input  logic [7:0] display1,
  input  logic [7:0] display2,
  input  logic [7:0] display3,
  input  logic       lamp_test,
  output logic [7:0] segments,
  output logic [3:0] anodes,
  output logic       frame_start
);

  localparam int CW = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [7:0]    frame [4];
  logic          capture;
  logic          blanking;

  assign capture  = (cnt == '0) && (idx == 2'd0);
  assign blanking = (cnt < CNT_BLANK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // All four codes are captured together so a mid-scan change never tears a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame[0]    <= 8'hFF;
      frame[1]    <= 8'hFF;
      frame[2]    <= 8'hFF;
      frame[3]    <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      frame_start <= capture;
      if (capture) begin
        frame[0] <= display0;
        frame[1] <= display1;
        frame[2] <= display2;
        frame[3] <= display3;
      end
    end
  end

  // Outputs are registered from the slot phase seen at this edge; lamp_test only overrides segments.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anodes   <= 4'hF;
      segments <= 8'hFF;
    end else if (blanking) begin
      anodes   <= 4'hF;
      segments <= 8'hFF;
    end else begin
      anodes   <= ~(4'b0001 << idx);
      segments <= lamp_test ? 8'h00 : frame[idx];
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with DWELL_CYCLES=8, BLANK_CYCLES=2.
module tb_display_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] display0 = 8'hFF;
  logic [7:0] display1 = 8'hFF;
  logic [7:0] display2 = 8'hFF;
  logic [7:0] display3 = 8'hFF;
  logic       lamp_test = 1'b0;
  logic [7:0] segments;
  logic [3:0] anodes;
  logic       frame_start;

  int errors = 0;
  int checks = 0;

  logic [3:0] drive_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  display_scanner #(.DWELL_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .display0(display0), .display1(display1),
    .display2(display2), .display3(display3),
    .lamp_test(lamp_test),
    .segments(segments), .anodes(anodes), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_codes(input logic [7:0] c0, input logic [7:0] c1,
                           input logic [7:0] c2, input logic [7:0] c3);
    display0 = c0;
    display1 = c1;
    display2 = c2;
    display3 = c3;
  endtask

  // Leaves rst low across one rising edge, returning at a falling edge.
  task automatic hold_reset();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_codes(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      lamp_test = 1'($urandom_range(0, 1));
      step();
      checks += 3;
      if (anodes !== 4'hF) begin errors++; $display("FAIL reset_anodes i=%0d got %h want f", i, anodes); end
      if (segments !== 8'hFF) begin errors++; $display("FAIL reset_segments i=%0d got %h want ff", i, segments); end
      if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start i=%0d got %b want 0", i, frame_start); end
    end
    lamp_test = 1'b0;
  endtask

  task automatic test_basic_scan();
    logic [7:0] codes [4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
    logic [3:0] ea;
    logic [7:0] es;
    logic       ef;
    hold_reset();
    set_codes(codes[0], codes[1], codes[2], codes[3]);
    rst = 1'b1;
    for (int k = 0; k < 64; k++) begin
      step();
      ea = (k % 8 < 2) ? 4'hF : drive_an[(k / 8) % 4];
      es = (k % 8 < 2) ? 8'hFF : codes[(k / 8) % 4];
      ef = (k % 32 == 0);
      checks += 3;
      if (anodes !== ea) begin errors++; $display("FAIL scan_anodes k=%0d got %h want %h", k, anodes, ea); end
      if (segments !== es) begin errors++; $display("FAIL scan_segments k=%0d got %h want %h", k, segments, es); end
      if (frame_start !== ef) begin errors++; $display("FAIL scan_frame_start k=%0d got %b want %b", k, frame_start, ef); end
    end
  endtask

  task automatic test_tear_free();
    logic [7:0] codes [4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
    logic [7:0] es;
    hold_reset();
    set_codes(codes[0], codes[1], codes[2], codes[3]);
    rst = 1'b1;
    for (int k = 0; k < 64; k++) begin
      step();
      es = (k % 8 < 2) ? 8'hFF : codes[(k / 8) % 4];
      checks += 1;
      if (segments !== es) begin errors++; $display("FAIL tear_segments k=%0d got %h want %h", k, segments, es); end
      if (k == 10) display2 = 8'h99;
      if (k == 31) codes[2] = 8'h99;
    end
  endtask

  task automatic test_lamp_test();
    logic [7:0] codes [4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
    logic [3:0] ea;
    logic [7:0] es;
    hold_reset();
    set_codes(codes[0], codes[1], codes[2], codes[3]);
    lamp_test = 1'b1;
    rst = 1'b1;
    for (int k = 0; k < 64; k++) begin
      step();
      ea = (k % 8 < 2) ? 4'hF : drive_an[(k / 8) % 4];
      es = (k % 8 < 2) ? 8'hFF : ((k < 32) ? 8'h00 : codes[(k / 8) % 4]);
      checks += 2;
      if (anodes !== ea) begin errors++; $display("FAIL lamp_anodes k=%0d got %h want %h", k, anodes, ea); end
      if (segments !== es) begin errors++; $display("FAIL lamp_segments k=%0d got %h want %h", k, segments, es); end
      if (k == 31) lamp_test = 1'b0;
    end
  endtask

  task automatic test_blank_frame();
    logic [3:0] ea;
    logic       ef;
    hold_reset();
    set_codes(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    rst = 1'b1;
    for (int k = 0; k < 64; k++) begin
      step();
      ea = (k % 8 < 2) ? 4'hF : drive_an[(k / 8) % 4];
      ef = (k % 32 == 0);
      checks += 3;
      if (anodes !== ea) begin errors++; $display("FAIL blank_anodes k=%0d got %h want %h", k, anodes, ea); end
      if (segments !== 8'hFF) begin errors++; $display("FAIL blank_segments k=%0d got %h want ff", k, segments); end
      if (frame_start !== ef) begin errors++; $display("FAIL blank_frame_start k=%0d got %b want %b", k, frame_start, ef); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] codes [4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
    logic [7:0] fresh [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [3:0] ea;
    logic [7:0] es;
    logic       ef;
    hold_reset();
    set_codes(codes[0], codes[1], codes[2], codes[3]);
    rst = 1'b1;
    for (int k = 0; k < 21; k++) step();
    checks += 2;
    if (anodes !== 4'hB) begin errors++; $display("FAIL mid_pre_anodes got %h want b", anodes); end
    if (segments !== 8'hA4) begin errors++; $display("FAIL mid_pre_segments got %h want a4", segments); end
    #2 rst = 1'b0;
    #1;
    checks += 3;
    if (anodes !== 4'hF) begin errors++; $display("FAIL mid_async_anodes got %h want f", anodes); end
    if (segments !== 8'hFF) begin errors++; $display("FAIL mid_async_segments got %h want ff", segments); end
    if (frame_start !== 1'b0) begin errors++; $display("FAIL mid_async_frame_start got %b want 0", frame_start); end
    @(negedge clk);
    set_codes(fresh[0], fresh[1], fresh[2], fresh[3]);
    rst = 1'b1;
    for (int k = 0; k < 32; k++) begin
      step();
      ea = (k % 8 < 2) ? 4'hF : drive_an[(k / 8) % 4];
      es = (k % 8 < 2) ? 8'hFF : fresh[(k / 8) % 4];
      ef = (k == 0);
      checks += 3;
      if (anodes !== ea) begin errors++; $display("FAIL mid_after_anodes k=%0d got %h want %h", k, anodes, ea); end
      if (segments !== es) begin errors++; $display("FAIL mid_after_segments k=%0d got %h want %h", k, segments, es); end
      if (frame_start !== ef) begin errors++; $display("FAIL mid_after_frame_start k=%0d got %b want %b", k, frame_start, ef); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_tear_free();
    test_lamp_test();
    test_blank_frame();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
